// File: rtl/link_motion_ctrl_if.sv
// ---------------------------------------------------------------------------
// link_motion_ctrl_if
//   Bundles the per-frame control inputs and the sprite state outputs of
//   link_motion_ctrl so the controller can be dropped between the keyboard
//   keycode register, the frame tick source and the sprite renderer.
//
//   Signals:
//     frame_tick  1  one-cycle pulse per frame (start of vertical blank)
//     keycode     8  current key code
//     collision   1  background wall hit at the current sprite position
//     spriteX    10  sprite left column
//     spriteY    10  sprite top row
//     facing      2  0 down, 1 up, 2 left, 3 right
//     anim_frame  1  walk-cycle frame
//     sprite_sel  3  {facing, anim_frame}, sprite ROM/palette index
//     moving      1  high while walking
//
//   Modports:
//     master  drives the inputs, observes the sprite state
//     slave   the motion controller itself
// ---------------------------------------------------------------------------
interface link_motion_ctrl_if;
    logic       frame_tick;
    logic [7:0] keycode;
    logic       collision;
    logic [9:0] spriteX;
    logic [9:0] spriteY;
    logic [1:0] facing;
    logic       anim_frame;
    logic [2:0] sprite_sel;
    logic       moving;

    modport master (
        output frame_tick, keycode, collision,
        input  spriteX, spriteY, facing, anim_frame, sprite_sel, moving
    );

    modport slave (
        input  frame_tick, keycode, collision,
        output spriteX, spriteY, facing, anim_frame, sprite_sel, moving
    );
endinterface

// File: rtl/link_motion_ctrl.sv
// ---------------------------------------------------------------------------
// link_motion_ctrl
//   Player sprite motion sequencer. Once per frame (on frame_tick) it decodes
//   the keycode into a facing direction, moves the sprite by STEP pixels
//   inside the playfield, runs the two-frame walk animation and backs out a
//   step that ran into a wall.
//
//   Ports:
//     vga_clk   in   pixel clock, the only clock
//     reset_n   in   asynchronous active-low reset
//     bus       slave side of link_motion_ctrl_if
//                 in : frame_tick, keycode, collision
//                 out: spriteX, spriteY, facing, anim_frame, sprite_sel, moving
//
//   All state and every output is registered and only changes on a clock
//   edge where frame_tick is high, so the renderer sees stable values for
//   the whole active frame that follows the tick.
//
//   Build option:
//     SPRITE_WRAP_EN  when defined, a step that leaves the playfield wraps
//                     to the opposite edge instead of clamping at the edge.
// ---------------------------------------------------------------------------
module link_motion_ctrl #(
    parameter int X_INIT    = 320,
    parameter int Y_INIT    = 240,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 608,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 448,
    parameter int STEP      = 1,
    parameter int FRAME_DIV = 8
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    link_motion_ctrl_if.slave bus
);

    localparam int CNT_W = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic signed [10:0] X_MIN_S = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
    localparam logic signed [10:0] Y_MIN_S = 11'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);

    localparam logic [1:0] DIR_DOWN  = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WALK    = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    // Bring an out-of-range coordinate back into [lo, hi].
    function automatic logic [9:0] fit(
        input logic signed [10:0] v,
        input logic signed [10:0] lo,
        input logic signed [10:0] hi
    );
        logic signed [10:0] r;
`ifdef SPRITE_WRAP_EN
        if (v > hi)
            r = lo + (v - hi - 11'sd1);
        else if (v < lo)
            r = hi - (lo - v - 11'sd1);
        else
            r = v;
`else
        if (v > hi)
            r = hi;
        else if (v < lo)
            r = lo;
        else
            r = v;
`endif
        return r[9:0];
    endfunction

    state_t           state_reg;
    logic [9:0]       x_reg;
    logic [9:0]       y_reg;
    logic [9:0]       prev_x_reg;
    logic [9:0]       prev_y_reg;
    logic [1:0]       facing_reg;
    logic [1:0]       last_dir_reg;
    logic [CNT_W-1:0] anim_cnt_reg;
    logic             anim_frame_reg;
    logic [2:0]       sprite_sel_reg;
    logic             moving_reg;

    logic             dir_valid;
    logic [1:0]       dir;
    logic signed [10:0] x_try;
    logic signed [10:0] y_try;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    logic [CNT_W-1:0] anim_cnt_next;
    logic             anim_frame_next;
    logic             take_step;

    // Keycode decode, candidate step position and animation advance.
    always_comb begin
        dir_valid = 1'b1;
        dir       = DIR_DOWN;
        case (bus.keycode)
            8'h1A:   dir = DIR_UP;
            8'h16:   dir = DIR_DOWN;
            8'h04:   dir = DIR_LEFT;
            8'h07:   dir = DIR_RIGHT;
            default: dir_valid = 1'b0;
        endcase

        x_try = $signed({1'b0, x_reg});
        y_try = $signed({1'b0, y_reg});
        case (dir)
            DIR_UP:    y_try = $signed({1'b0, y_reg}) - STEP_S;
            DIR_DOWN:  y_try = $signed({1'b0, y_reg}) + STEP_S;
            DIR_LEFT:  x_try = $signed({1'b0, x_reg}) - STEP_S;
            default:   x_try = $signed({1'b0, x_reg}) + STEP_S;
        endcase
        x_next = fit(x_try, X_MIN_S, X_MAX_S);
        y_next = fit(y_try, Y_MIN_S, Y_MAX_S);

        if (anim_cnt_reg == CNT_LAST) begin
            anim_cnt_next   = '0;
            anim_frame_next = ~anim_frame_reg;
        end else begin
            anim_cnt_next   = anim_cnt_reg + 1'b1;
            anim_frame_next = anim_frame_reg;
        end

        // A step is taken from IDLE on any key, from WALK unless a wall was
        // hit (the wall wins over the key), and from BLOCKED only when the
        // player turns away from the direction that ran into the wall.
        take_step = 1'b0;
        if (dir_valid) begin
            case (state_reg)
                IDLE:    take_step = 1'b1;
                WALK:    take_step = ~bus.collision;
                BLOCKED: take_step = (dir != last_dir_reg);
                default: take_step = 1'b0;
            endcase
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            x_reg          <= 10'(X_INIT);
            y_reg          <= 10'(Y_INIT);
            prev_x_reg     <= 10'(X_INIT);
            prev_y_reg     <= 10'(Y_INIT);
            facing_reg     <= DIR_DOWN;
            last_dir_reg   <= DIR_DOWN;
            anim_cnt_reg   <= '0;
            anim_frame_reg <= 1'b0;
            sprite_sel_reg <= 3'd0;
            moving_reg     <= 1'b0;
        end else if (bus.frame_tick) begin
            if (take_step) begin
                // A clamped step still counts as a step: prev is saved and
                // the walk animation keeps cycling.
                prev_x_reg     <= x_reg;
                prev_y_reg     <= y_reg;
                x_reg          <= x_next;
                y_reg          <= y_next;
                facing_reg     <= dir;
                last_dir_reg   <= dir;
                anim_cnt_reg   <= anim_cnt_next;
                anim_frame_reg <= anim_frame_next;
                sprite_sel_reg <= {dir, anim_frame_next};
                moving_reg     <= 1'b1;
                state_reg      <= WALK;
            end else begin
                case (state_reg)
                    IDLE: begin
                        anim_cnt_reg   <= '0;
                        anim_frame_reg <= 1'b0;
                        sprite_sel_reg <= {facing_reg, 1'b0};
                        moving_reg     <= 1'b0;
                    end
                    WALK: begin
                        if (bus.collision) begin
                            // Back out the step that entered the wall;
                            // animation freezes where it was.
                            x_reg      <= prev_x_reg;
                            y_reg      <= prev_y_reg;
                            moving_reg <= 1'b0;
                            state_reg  <= BLOCKED;
                        end else begin
                            anim_cnt_reg   <= '0;
                            anim_frame_reg <= 1'b0;
                            sprite_sel_reg <= {facing_reg, 1'b0};
                            moving_reg     <= 1'b0;
                            state_reg      <= IDLE;
                        end
                    end
                    BLOCKED: begin
                        // Still pushing into the wall: hold everything.
                        if (!dir_valid) begin
                            anim_cnt_reg   <= '0;
                            anim_frame_reg <= 1'b0;
                            sprite_sel_reg <= {facing_reg, 1'b0};
                            moving_reg     <= 1'b0;
                            state_reg      <= IDLE;
                        end
                    end
                    default: begin
                        moving_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.spriteX    = x_reg;
    assign bus.spriteY    = y_reg;
    assign bus.facing     = facing_reg;
    assign bus.anim_frame = anim_frame_reg;
    assign bus.sprite_sel = sprite_sel_reg;
    assign bus.moving     = moving_reg;

endmodule

// File: doc/link_motion_ctrl.md
Name: link_motion_ctrl

Overview:
- Sequences the player sprite datapath once per video frame.
- Decodes the movement keycode into a facing direction and moves spriteX/spriteY by STEP pixels, clamped to the playfield.
- Runs the two-frame walk animation and selects which sprite ROM/palette pair the renderer displays.
- Undoes a step when the background-collision probe flags a wall.
- Sits between the keyboard keycode register, the per-frame tick and the sprite renderer.

Parameters:
- X_INIT, 320: spriteX after reset.
- Y_INIT, 240: spriteY after reset.
- X_MIN, 0: minimum spriteX.
- X_MAX, 608: maximum spriteX (640 minus the 32-pixel sprite).
- Y_MIN, 0: minimum spriteY.
- Y_MAX, 448: maximum spriteY.
- STEP, 1: pixels moved per frame tick; 1..15.
- FRAME_DIV, 8: frame ticks per animation toggle; at least 2.

Ports:
- vga_clk  in  1  pixel clock, sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-vga_clk pulse per frame, issued at start of vertical blank.
- keycode  in  8  current key: 0x1A up, 0x16 down, 0x04 left, 0x07 right; any other value means idle.
- collision  in  1  wall hit at the current sprite position; valid whenever frame_tick is high.
- spriteX  out  10  sprite left column.
- spriteY  out  10  sprite top row.
- facing  out  2  0 down, 1 up, 2 left, 3 right.
- anim_frame  out  1  walk-cycle frame.
- sprite_sel  out  3  {facing, anim_frame}; indexes the sprite ROM/palette pair.
- moving  out  1  high while in WALK.

Behaviour:
- Reset (async, reset_n low):
  - spriteX=X_INIT, spriteY=Y_INIT, facing=0, anim_frame=0, sprite_sel=0, moving=0.
  - State=IDLE, anim counter=0, prev_X/prev_Y=X_INIT/Y_INIT, last_dir=0.
  - Reset asserted mid-move aborts the move immediately; no partial update survives.
- Timing:
  - All state and outputs change only on a vga_clk edge where frame_tick=1.
  - Outputs are registered and valid 1 cycle after the tick, so they are stable for the whole next active frame.
  - keycode and collision are sampled only on the tick.
- Direction decode: 0x1A→1, 0x16→0, 0x04→2, 0x07→3, otherwise none.
- States:
  - IDLE:
    - No direction: stay in IDLE; anim counter=0, anim_frame=0.
    - Valid direction: set facing=dir and last_dir=dir, save prev_X/Y=current position, apply step, go to WALK.
  - WALK:
    - If collision=1: restore spriteX/Y=prev_X/Y, hold anim, go to BLOCKED. Collision takes priority over the key on the same tick.
    - Else if no direction: go to IDLE; anim counter=0, anim_frame=0.
    - Else: facing=dir, save prev, apply step, advance the anim counter. When the counter reaches FRAME_DIV-1 it wraps to 0 and anim_frame toggles. A direction change updates facing and the step in the same tick.
  - BLOCKED:
    - No direction: go to IDLE.
    - dir==last_dir: stay in BLOCKED; position and anim held.
    - dir!=last_dir: behave as the IDLE→WALK move (save prev, step, go to WALK).
- Step arithmetic:
  - Computed in 11-bit signed: up Y-STEP, down Y+STEP, left X-STEP, right X+STEP.
  - Result is clamped to [MIN, MAX].
  - A clamped (zero-length) step is still a step: prev is saved and anim advances.
- moving=1 exactly in WALK. sprite_sel = facing*2 + anim_frame.

Optional Feature:
- Macro: SPRITE_WRAP_EN.
- Defined: out-of-range results wrap instead of clamping.
  - Result > MAX becomes MIN + (result - MAX - 1).
  - Result < MIN becomes MAX - (MIN - result - 1).
  - Example: X=608, right, STEP=1 → X=0.
- Undefined: clamp as above; the wrap logic is not present.

Test Plan:
- Reset released, keycode=0x00, 5 ticks → spriteX=320, spriteY=240, sprite_sel=0, moving=0 throughout.
- keycode=0x07 held for 16 ticks with defaults → spriteX=336, moving=1, facing=3. anim_frame toggles after tick 8 and again after tick 16. sprite_sel alternates 6/7. Nothing changes between ticks.
- keycode=0x1A from Y=240; collision=1 on tick 4 → Y=237 after tick 3, Y=238 after tick 4 (restored), BLOCKED. Ticks 5-8 with 0x1A: Y stays 238. Switch to 0x16: Y=239, WALK.
- From X=2, keycode=0x04, STEP=4 → X=0 after 1 tick and stays 0, moving=1. With SPRITE_WRAP_EN: X=607 after the first tick.
- Walking right mid-animation (anim_frame=1), then reset_n pulsed low between ticks → all outputs at reset values immediately, without waiting for a clock edge.
- Walking, then keycode=0x55 → IDLE on the next tick: anim_frame=0, position held, facing unchanged.
